// File: rtl/wb_stream_dma_pkg.sv
// rtl/wb_stream_dma_pkg.sv - FSM state and Wishbone CTI encodings shared by the stream writer DMA
package wb_stream_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_stream_dma_fifo.sv
// rtl/wb_stream_dma_fifo.sv - first-word-fall-through FIFO with free-word count
module wb_stream_dma_fifo #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [AW:0]      free
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign valid   = (count != '0);
    assign do_rd   = rd_en && valid;
    assign do_wr   = wr_en && (count != DEPTH_W);
    assign rd_data = mem[rd_ptr];
    assign free    = DEPTH_W - count;

    // storage is deliberately not reset; count alone defines what is valid
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_stream_writer_dma.sv
// rtl/wb_stream_writer_dma.sv - Wishbone burst reader feeding a stream port; irq via WB_STREAM_WRITER_DMA_IRQ_EN
module wb_stream_writer_dma
    import wb_stream_dma_pkg::*;
#(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 128,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WB_AW-1:0]     cfg_start_adr_i,
    input  logic [CNT_W-1:0]     cfg_buf_size_i,
    input  logic [7:0]           cfg_burst_size_i,
    input  logic                 cfg_circular_i,
    input  logic                 cfg_enable_i,
    input  logic                 cfg_stop_i,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    output logic [WB_DW-1:0]     stream_m_data_o,
    output logic                 stream_m_valid_o,
    input  logic                 stream_m_ready_i,
    output logic                 irq_o
);

    localparam int WSB     = WB_DW / 8;
    localparam int WSB_LOG = $clog2(WSB);
    localparam logic [WB_AW-1:0] ADR_STEP = WB_AW'(WSB);
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(WSB);
    localparam logic [7:0]       MAX_LEN  = 8'(MAX_BURST_LEN);

    dma_state_t       state_q;
    dma_state_t       state_d;
    logic [WB_AW-1:0] start_adr_q;
    logic [WB_AW-1:0] adr_q;
    logic [CNT_W-1:0] buf_size_q;
    logic [CNT_W-1:0] remaining_q;
    logic [7:0]       burst_len_q;
    logic [7:0]       beats_left_q;
    logic             circular_q;
    logic             stop_q;
    logic             busy_q;
    logic             err_q;
    logic             cyc_q;
    logic [2:0]       cti_q;

    logic             fifo_valid;
    logic [FIFO_AW:0] fifo_free;

    logic [CNT_W-1:0] words_rem;
    logic [7:0]       len;
    logic [7:0]       burst_clamp;
    logic [CNT_W-1:0] rem_after;
    logic             space_ok;
    logic             stop_eff;
    logic             last_beat;

    logic do_start, do_launch, beat_ack, end_cycle, do_wrap, do_abort, go_idle;

    assign words_rem   = remaining_q >> WSB_LOG;
    assign len         = (CNT_W'(burst_len_q) <= words_rem) ? burst_len_q : words_rem[7:0];
    assign burst_clamp = (32'(cfg_burst_size_i) > MAX_BURST_LEN) ? MAX_LEN : cfg_burst_size_i;
    assign rem_after   = remaining_q - CNT_STEP;
    assign space_ok    = 32'(fifo_free) >= 32'(len);
    assign stop_eff    = stop_q || cfg_stop_i;
    assign last_beat   = (beats_left_q == 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        do_start  = 1'b0;
        do_launch = 1'b0;
        beat_ack  = 1'b0;
        end_cycle = 1'b0;
        do_wrap   = 1'b0;
        do_abort  = 1'b0;
        go_idle   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable_i) begin
                    do_start = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (stop_eff) begin
                    state_d = ST_DONE;
                end else if (space_ok) begin
                    do_launch = 1'b1;
                    state_d   = ST_BURST;
                end
            end
            ST_BURST: begin
                // rty is simply a beat without ack: stb stays up and the address holds
                if (wbm_err_i) begin
                    do_abort  = 1'b1;
                    end_cycle = 1'b1;
                    state_d   = ST_DONE;
                end else if (wbm_ack_i && !wbm_rty_i) begin
                    beat_ack = 1'b1;
                    if (last_beat) begin
                        end_cycle = 1'b1;
                        if (rem_after != '0) begin
                            state_d = stop_eff ? ST_DONE : ST_WAIT;
                        end else if (circular_q && !stop_eff) begin
                            do_wrap = 1'b1;
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!fifo_valid) begin
                    go_idle = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // later statements override earlier ones: the wrap reload wins over the beat increment
    always_ff @(posedge clk) begin
        if (rst) begin
            start_adr_q  <= '0;
            adr_q        <= '0;
            buf_size_q   <= '0;
            remaining_q  <= '0;
            burst_len_q  <= '0;
            beats_left_q <= '0;
            circular_q   <= 1'b0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            cyc_q        <= 1'b0;
            cti_q        <= CTI_CLASSIC;
        end else begin
            if (do_start) begin
                start_adr_q <= cfg_start_adr_i;
                adr_q       <= cfg_start_adr_i;
                buf_size_q  <= cfg_buf_size_i;
                remaining_q <= cfg_buf_size_i;
                burst_len_q <= burst_clamp;
                circular_q  <= cfg_circular_i;
                stop_q      <= 1'b0;
                busy_q      <= 1'b1;
                err_q       <= 1'b0;
            end
            if (state_q != ST_IDLE && cfg_stop_i) begin
                stop_q <= 1'b1;
            end
            if (do_launch) begin
                cyc_q        <= 1'b1;
                beats_left_q <= len;
                cti_q        <= (len == 8'd1) ? CTI_EOB : CTI_INC;
            end
            if (beat_ack) begin
                adr_q        <= adr_q + ADR_STEP;
                remaining_q  <= rem_after;
                beats_left_q <= beats_left_q - 8'd1;
                cti_q        <= (beats_left_q == 8'd2) ? CTI_EOB : CTI_INC;
            end
            if (end_cycle) begin
                cyc_q <= 1'b0;
                cti_q <= CTI_CLASSIC;
            end
            if (do_wrap) begin
                adr_q       <= start_adr_q;
                remaining_q <= buf_size_q;
            end
            if (do_abort) begin
                err_q <= 1'b1;
            end
            if (go_idle) begin
                busy_q <= 1'b0;
            end
        end
    end

    wb_stream_dma_fifo #(
        .WIDTH (WB_DW),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (beat_ack),
        .wr_data (wbm_dat_i),
        .rd_en   (stream_m_ready_i),
        .rd_data (stream_m_data_o),
        .valid   (fifo_valid),
        .free    (fifo_free)
    );

    assign busy_o           = busy_q;
    assign err_o            = err_q;
    assign wbm_adr_o        = adr_q;
    assign wbm_dat_o        = '0;
    assign wbm_sel_o        = '1;
    assign wbm_we_o         = 1'b0;
    assign wbm_cyc_o        = cyc_q;
    assign wbm_stb_o        = cyc_q;
    assign wbm_cti_o        = cti_q;
    assign wbm_bte_o        = 2'b00;
    assign stream_m_valid_o = fifo_valid;

`ifdef WB_STREAM_WRITER_DMA_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= go_idle || do_wrap;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stream_writer_dma.sv
// tb/tb_wb_stream_writer_dma.sv - randomized self-checking bench for wb_stream_writer_dma
module tb_wb_stream_writer_dma;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int FAW     = 5;
    localparam int MAXB    = 16;
    localparam int CW      = 16;
    localparam int DEPTH   = 1 << FAW;
`ifdef WB_STREAM_WRITER_DMA_IRQ_EN
    localparam int IRQ_ON  = 1;
`else
    localparam int IRQ_ON  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cfg_start_adr_i = '0;
    logic [CW-1:0] cfg_buf_size_i = '0;
    logic [7:0]    cfg_burst_size_i = '0;
    logic          cfg_circular_i = 1'b0;
    logic          cfg_enable_i = 1'b0;
    logic          cfg_stop_i = 1'b0;
    logic          busy_o, err_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW/8-1:0] wbm_sel_o;
    logic          wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]    wbm_cti_o;
    logic [1:0]    wbm_bte_o;
    logic [DW-1:0] wbm_dat_i = '0;
    logic          wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
    logic [DW-1:0] stream_m_data_o;
    logic          stream_m_valid_o;
    logic          stream_m_ready_i = 1'b0;
    logic          irq_o;

    always #5 clk = ~clk;

    wb_stream_writer_dma #(
        .WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW), .MAX_BURST_LEN(MAXB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_start_adr_i(cfg_start_adr_i), .cfg_buf_size_i(cfg_buf_size_i),
        .cfg_burst_size_i(cfg_burst_size_i), .cfg_circular_i(cfg_circular_i),
        .cfg_enable_i(cfg_enable_i), .cfg_stop_i(cfg_stop_i),
        .busy_o(busy_o), .err_o(err_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
        .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
        .stream_m_ready_i(stream_m_ready_i), .irq_o(irq_o)
    );

    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    int beat_idx = 0, xfer_cnt = 0, irq_cnt = 0, err_beat = -1;
    int max_occ = 0, launch_occ_max = 0, launches = 0, rty_adr_bad = 0;
    int cyc_after_err = -1, ready_mode = 0, stall_cnt = 0;
    bit err_seen = 0;
    logic prev_cyc = 1'b0;
    logic [63:0] rty_mask = '0, rty_used = '0;
    logic [31:0] rty_adr = '0;
    logic [31:0] got_adr[$], got_data[$], exp_adr[$], exp_data[$];
    logic [2:0]  got_cti[$], exp_cti[$];
    int exp_bursts = 0;

    // memory slave, stream sink and occupancy monitor all live on the falling edge
    always @(negedge clk) begin
        int occ;
        occ = beat_idx - xfer_cnt;
        if (occ > max_occ) max_occ = occ;
        if (wbm_cyc_o && !prev_cyc) begin
            launches++;
            if (occ > launch_occ_max) launch_occ_max = occ;
        end
        prev_cyc = wbm_cyc_o;
        if (err_seen) begin
            cyc_after_err = int'(wbm_cyc_o);
            err_seen = 0;
        end
        if (irq_o) irq_cnt++;
        case (ready_mode)
            0: stream_m_ready_i = 1'b1;
            1: stream_m_ready_i = 1'($urandom_range(0, 1));
            default: begin
                if (stall_cnt > 0) begin
                    stream_m_ready_i = 1'b0;
                    stall_cnt--;
                end else begin
                    stream_m_ready_i = 1'b1;
                end
            end
        endcase
        if (stream_m_valid_o && stream_m_ready_i && !rst) begin
            got_data.push_back(stream_m_data_o);
            xfer_cnt++;
        end
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_rty_i = 1'b0;
        if (wbm_cyc_o && wbm_stb_o) begin
            wbm_dat_i = mem[wbm_adr_o[9:2]];
            if (beat_idx == err_beat) begin
                wbm_err_i = 1'b1;
                err_beat = -1;
                err_seen = 1;
            end else if (beat_idx < 64 && rty_mask[beat_idx] && !rty_used[beat_idx]) begin
                wbm_rty_i = 1'b1;
                rty_used[beat_idx] = 1'b1;
                rty_adr = wbm_adr_o;
            end else begin
                if (beat_idx < 64 && rty_used[beat_idx] && wbm_adr_o !== rty_adr) rty_adr_bad++;
                wbm_ack_i = 1'b1;
                got_adr.push_back(wbm_adr_o);
                got_cti.push_back(wbm_cti_o);
                beat_idx++;
            end
        end
    end

    task automatic reset_monitor();
        beat_idx = 0; xfer_cnt = 0; irq_cnt = 0; err_beat = -1;
        max_occ = 0; launch_occ_max = 0; launches = 0; rty_adr_bad = 0;
        cyc_after_err = -1; rty_mask = '0; rty_used = '0;
        got_adr.delete(); got_data.delete(); got_cti.delete();
    endtask

    // reference: the buffer is cut into bursts of min(burst, words left), repeated per lap
    task automatic build_expect(input logic [31:0] start, input int nbytes, input int burst, input int laps);
        int words, b, done, blen;
        words = nbytes / 4;
        b = (burst > MAXB) ? MAXB : burst;
        exp_adr.delete(); exp_cti.delete(); exp_data.delete();
        exp_bursts = 0;
        for (int lap = 0; lap < laps; lap++) begin
            done = 0;
            while (done < words) begin
                blen = (words - done < b) ? words - done : b;
                exp_bursts++;
                for (int k = 0; k < blen; k++) begin
                    exp_adr.push_back(start + 32'(4 * (done + k)));
                    exp_cti.push_back((k == blen - 1) ? 3'b111 : 3'b010);
                    exp_data.push_back(mem[((start >> 2) + 32'(done + k)) & 32'hFF]);
                end
                done += blen;
            end
        end
    endtask

    task automatic start_run(input logic [31:0] start, input int nbytes, input int burst, input bit circ);
        @(posedge clk); #1;
        cfg_start_adr_i = start;
        cfg_buf_size_i = 16'(nbytes);
        cfg_burst_size_i = 8'(burst);
        cfg_circular_i = circ;
        cfg_enable_i = 1'b1;
        @(posedge clk); #1;
        cfg_enable_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!busy_o) begin
                ok = 1;
                break;
            end
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b exp 0", wbm_cyc_o); end
        checks++; if (wbm_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb got %b exp 0", wbm_stb_o); end
        checks++; if (wbm_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", wbm_adr_o); end
        checks++; if (wbm_cti_o !== 3'b000) begin errors++; $display("FAIL reset_cti got %b exp 000", wbm_cti_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq_o); end
        checks++; if (stream_m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", stream_m_valid_o); end
        checks++; if (wbm_we_o !== 1'b0 || wbm_bte_o !== 2'b00 || wbm_dat_o !== 32'h0)
            begin errors++; $display("FAIL reset_tieoffs got we=%b bte=%b dat=%h exp 0/00/0", wbm_we_o, wbm_bte_o, wbm_dat_o); end
        checks++; if (wbm_sel_o !== 4'hF) begin errors++; $display("FAIL reset_sel got %h exp f", wbm_sel_o); end
    endtask

    task automatic test_linear(input string name, input logic [31:0] start, input int nbytes,
                               input int burst, input int rmode);
        bit ok;
        reset_monitor();
        ready_mode = rmode;
        build_expect(start, nbytes, burst, 1);
        start_run(start, nbytes, burst, 1'b0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL %s_busy_rise got %b exp 1", name, busy_o); end
        wait_idle(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_timeout got busy=1 exp busy=0", name); end
        checks++; if (got_data.size() != exp_data.size())
            begin errors++; $display("FAIL %s_words got %0d exp %0d", name, got_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_data[i])
                begin errors++; $display("FAIL %s_data[%0d] got %h exp %h", name, i, got_data[i], exp_data[i]); end
        end
        for (int i = 0; i < exp_adr.size() && i < got_adr.size(); i++) begin
            checks++; if (got_adr[i] !== exp_adr[i] || got_cti[i] !== exp_cti[i])
                begin errors++; $display("FAIL %s_beat[%0d] got adr=%h cti=%b exp adr=%h cti=%b",
                                         name, i, got_adr[i], got_cti[i], exp_adr[i], exp_cti[i]); end
        end
        checks++; if (launches != exp_bursts) begin errors++; $display("FAIL %s_bursts got %0d exp %0d", name, launches, exp_bursts); end
        checks++; if (irq_cnt != IRQ_ON) begin errors++; $display("FAIL %s_irq got %0d exp %0d", name, irq_cnt, IRQ_ON); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL %s_err got %b exp 0", name, err_o); end
    endtask

    task automatic test_circular(input int laps);
        bit ok;
        int budget;
        reset_monitor();
        ready_mode = 2;
        stall_cnt = 50;
        build_expect(32'h200, 32, 8, laps);
        start_run(32'h200, 32, 8, 1'b1);
        budget = 0;
        while (beat_idx < 8 * (laps - 1) + 1 && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++; if (budget >= 2000) begin errors++; $display("FAIL circ%0d_lap_timeout got %0d beats exp %0d", laps, beat_idx, 8 * (laps - 1) + 1); end
        cfg_stop_i = 1'b1;
        @(posedge clk); #1;
        cfg_stop_i = 1'b0;
        wait_idle(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL circ%0d_timeout got busy=1 exp busy=0", laps); end
        checks++; if (got_data.size() != 8 * laps) begin errors++; $display("FAIL circ%0d_words got %0d exp %0d", laps, got_data.size(), 8 * laps); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_data[i])
                begin errors++; $display("FAIL circ%0d_data[%0d] got %h exp %h", laps, i, got_data[i], exp_data[i]); end
        end
        for (int i = 0; i < exp_adr.size() && i < got_adr.size(); i++) begin
            checks++; if (got_adr[i] !== exp_adr[i])
                begin errors++; $display("FAIL circ%0d_adr[%0d] got %h exp %h", laps, i, got_adr[i], exp_adr[i]); end
        end
        checks++; if (launch_occ_max > DEPTH - 8) begin errors++; $display("FAIL circ%0d_launch_space got occ %0d exp <= %0d", laps, launch_occ_max, DEPTH - 8); end
        checks++; if (max_occ > DEPTH) begin errors++; $display("FAIL circ%0d_overflow got occ %0d exp <= %0d", laps, max_occ, DEPTH); end
        if (laps >= 5) begin
            checks++; if (max_occ != DEPTH) begin errors++; $display("FAIL circ%0d_fill got occ %0d exp %0d", laps, max_occ, DEPTH); end
        end
        checks++; if (irq_cnt != IRQ_ON * laps) begin errors++; $display("FAIL circ%0d_irq got %0d exp %0d", laps, irq_cnt, IRQ_ON * laps); end
    endtask

    task automatic test_error();
        bit ok;
        reset_monitor();
        ready_mode = 1;
        err_beat = 10;
        build_expect(32'h40, 128, 8, 1);
        start_run(32'h40, 128, 8, 1'b0);
        wait_idle(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL error_timeout got busy=1 exp busy=0"); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL error_flag got %b exp 1", err_o); end
        checks++; if (cyc_after_err != 0) begin errors++; $display("FAIL error_cyc_drop got %0d exp 0", cyc_after_err); end
        checks++; if (got_data.size() != 10) begin errors++; $display("FAIL error_words got %0d exp 10", got_data.size()); end
        for (int i = 0; i < 10 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_data[i])
                begin errors++; $display("FAIL error_data[%0d] got %h exp %h", i, got_data[i], exp_data[i]); end
        end
        checks++; if (launches != 2) begin errors++; $display("FAIL error_bursts got %0d exp 2", launches); end
        reset_monitor();
        start_run(32'h0, 16, 4, 1'b0);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL error_clear got %b exp 0", err_o); end
        wait_idle(1000, ok);
        checks++; if (!ok || got_data.size() != 4) begin errors++; $display("FAIL error_rerun got %0d words exp 4", got_data.size()); end
    endtask

    task automatic test_retry();
        bit ok;
        reset_monitor();
        ready_mode = 0;
        rty_mask = 64'h12;
        build_expect(32'h140, 64, 8, 1);
        start_run(32'h140, 64, 8, 1'b0);
        wait_idle(2000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL retry_timeout got busy=1 exp busy=0"); end
        checks++; if (rty_used !== 64'h12) begin errors++; $display("FAIL retry_issued got %h exp 12", rty_used); end
        checks++; if (rty_adr_bad != 0) begin errors++; $display("FAIL retry_adr_held got %0d moves exp 0", rty_adr_bad); end
        checks++; if (got_data.size() != 16) begin errors++; $display("FAIL retry_words got %0d exp 16", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_data[i] || got_adr[i] !== exp_adr[i])
                begin errors++; $display("FAIL retry_beat[%0d] got %h@%h exp %h@%h", i, got_data[i], got_adr[i], exp_data[i], exp_adr[i]); end
        end
    endtask

    task automatic test_reset_midburst();
        int budget;
        reset_monitor();
        ready_mode = 0;
        start_run(32'h100, 128, 8, 1'b0);
        budget = 0;
        while (beat_idx < 3 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++; if (wbm_cyc_o !== 1'b1) begin errors++; $display("FAIL midrst_in_burst got cyc=%b exp 1", wbm_cyc_o); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (wbm_cyc_o !== 1'b0 || stream_m_valid_o !== 1'b0 || busy_o !== 1'b0)
            begin errors++; $display("FAIL midrst_state got cyc=%b valid=%b busy=%b exp 0/0/0", wbm_cyc_o, stream_m_valid_o, busy_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        test_linear("after_reset", 32'h20, 48, 8, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_linear("basic", 32'h40, 128, 8, 0);
        test_linear("tail1", 32'h80, 36, 4, 1);
        test_linear("clamp", 32'h10, 160, 200, 1);
        for (int r = 0; r < 4; r++) begin
            test_linear($sformatf("rand%0d", r), 32'($urandom_range(0, 64)) * 4,
                        4 * $urandom_range(1, 40), $urandom_range(1, 12), 1);
        end
        test_circular(3);
        test_circular(6);
        test_error();
        test_retry();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stream_writer_dma.md
Name: wb_stream_writer_dma

Overview:
Parametrised memory-to-stream reader. A Wishbone B3 burst master fetches a configured buffer and pushes the words through an internal FWFT FIFO to a valid/ready stream master port. Generalises the single-shot 32-bit writer in three ways: configurable data width, circular (continuous) mode, and an error-abort path. Sits between system memory and stream sinks such as DAC or video outputs.

Parameters:
WB_AW, 32, Wishbone address width.
WB_DW, 32, data width; one of 32/64/128. WSB = WB_DW/8 bytes per word.
FIFO_AW, 5, FIFO depth = 2**FIFO_AW words.
MAX_BURST_LEN, 128, max burst in words; cfg_burst_size is clamped to this.
CNT_W, 16, width of the byte counter and of cfg_buf_size.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
cfg_start_adr_i  in  WB_AW  buffer start byte address, WSB-aligned
cfg_buf_size_i  in  CNT_W  buffer size in bytes, multiple of WSB, nonzero
cfg_burst_size_i  in  8  words per burst, nonzero
cfg_circular_i  in  1  1 = wrap to start forever
cfg_enable_i  in  1  start pulse, sampled in IDLE only
cfg_stop_i  in  1  request stop at next burst boundary
busy_o  out  1  engine active
err_o  out  1  sticky bus error, cleared by next start
wbm_adr_o  out  WB_AW  byte address
wbm_dat_o  out  WB_DW  tied 0
wbm_sel_o  out  WSB  all ones
wbm_we_o  out  1  tied 0
wbm_cyc_o, wbm_stb_o  out  1  cycle/strobe
wbm_cti_o  out  3  010 incrementing, 111 last
wbm_bte_o  out  2  tied 00 (linear)
wbm_dat_i  in  WB_DW  read data
wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  slave responses
stream_m_data_o  out  WB_DW  stream data
stream_m_valid_o  out  1  FIFO not empty
stream_m_ready_i  in  1  sink accepts
irq_o  out  1  see Optional Feature

Behaviour:
- Reset: FSM IDLE, cyc/stb 0, adr 0, cti 000, busy 0, err 0, irq 0, FIFO emptied, valid 0. A reset mid-burst drops cyc on the same edge, with no completion.
- States: IDLE, WAIT, BURST, DONE.
- IDLE: cfg_enable_i=1 latches start_adr, buf_size, burst_len = min(cfg_burst_size_i, MAX_BURST_LEN) and circular. It then sets adr=start, remaining=buf_size, busy=1, err=0, and goes to WAIT. Enable is ignored outside IDLE.
- WAIT: compute len = min(burst_len, remaining/WSB). Enter BURST when FIFO free words >= len; in BURST, cyc and stb are asserted from the next cycle.
- BURST: cti=010, except 111 on the last beat of len (len=1 gives 111 immediately). Each ack writes dat_i to the FIFO, adds WSB to adr and subtracts WSB from remaining. After the last ack, cyc and stb drop on the following edge. Then:
  - remaining=0 and circular=1 and no stop pending: adr=start, remaining=buf_size, go to WAIT.
  - remaining=0 otherwise: go to DONE.
  - remaining>0: go to WAIT, or to DONE if stop is pending.
- rty: treated as a non-ack wait state; stb stays asserted and the beat is retried.
- err: terminates the cycle immediately, with no FIFO write. err_o is set and the FSM goes to DONE.
- cfg_stop_i: latched as stop-pending in any active state. It never truncates a burst in flight. In WAIT it goes to DONE directly.
- DONE: busy is held until the FIFO has drained (valid=0), then busy=0 and return to IDLE.
- Stream: FWFT; data is valid the same cycle as valid. A word transfers when valid&&ready. FIFO write and read may occur in the same cycle. The FIFO never overflows because a burst is only issued with guaranteed space.
- adr increments modulo 2**WB_AW; no 1KB boundary handling.

Optional Feature:
- Macro WB_STREAM_WRITER_DMA_IRQ_EN.
- Defined: irq_o is a one-cycle pulse on DONE to IDLE. In circular mode it also pulses on each wrap to start.
- Undefined: irq_o is tied 0 and no irq logic is generated.

Decomposition:
- Package wb_stream_dma_pkg holds the FSM state enum and the CTI constants CTI_CLASSIC=000, CTI_INC=010, CTI_EOB=111.
- One sub-module, wb_stream_dma_fifo: an FWFT FIFO with parameters WIDTH and AW, exposing a free-word count output.

Test Plan:
- WB_DW=32, start 0x40, buf 128 B, burst 8, sink always ready -> 4 bursts of 8, cti 010×7 then 111, 32 words matching mem[0x10..0x2F], then busy falls.
- WB_DW=64, start 0x80, buf 40 B, burst 4 -> bursts of 4 then 1 (cti 111 only), 5 words, adr 0x80..0xA0.
- Circular, buf 32 B, burst 8, sink stalls 50 cycles -> cyc held low while FIFO free < 8, no overflow, data wraps to start; stop after 3 laps -> exactly 24 words, then idle.
- err_i asserted on beat 3 of the second burst -> cyc drops that cycle, err_o=1, 10 words delivered, busy falls after drain; the next enable clears err_o.
- rty_i on beats 2 and 5 -> beats retried, same address held, data correct.
- Reset asserted mid-burst -> cyc=0, valid=0, busy=0 on the next edge; a new enable completes a clean run.
